// File: rtl/uart_mem_load_ctrl_if.sv
// Bundle of UART packet, CPU data-port, memory and transmitter signals around
// the load controller. The master modport is the controller's view.
interface uart_mem_load_ctrl_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
);
   logic              rx_done;
   logic [DATA_W-1:0] rx_data;
   logic [ADDR_W-1:0] rx_addr;
   logic              rx_mem_type;
   logic              rx_rw;

   logic              cpu_stall;
   logic              busy;
   logic              rx_dropped;

   logic              cpu_dmem_we;
   logic              cpu_dmem_re;
   logic [ADDR_W-1:0] cpu_dmem_addr;
   logic [DATA_W-1:0] cpu_dmem_wdata;

   logic              dmem_we;
   logic              dmem_re;
   logic [ADDR_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_wdata;
   logic [DATA_W-1:0] dmem_rdata;

   logic              imem_we;
   logic              imem_re;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_wdata;
   logic [DATA_W-1:0] imem_rdata;

   logic              tx_start;
   logic [7:0]        tx_byte;
   logic              tx_busy;

   modport master (
      input  rx_done, rx_data, rx_addr, rx_mem_type, rx_rw,
      input  cpu_dmem_we, cpu_dmem_re, cpu_dmem_addr, cpu_dmem_wdata,
      input  dmem_rdata, imem_rdata, tx_busy,
      output cpu_stall, busy, rx_dropped,
      output dmem_we, dmem_re, dmem_addr, dmem_wdata,
      output imem_we, imem_re, imem_addr, imem_wdata,
      output tx_start, tx_byte
   );

   modport slave (
      output rx_done, rx_data, rx_addr, rx_mem_type, rx_rw,
      output cpu_dmem_we, cpu_dmem_re, cpu_dmem_addr, cpu_dmem_wdata,
      output dmem_rdata, imem_rdata, tx_busy,
      input  cpu_stall, busy, rx_dropped,
      input  dmem_we, dmem_re, dmem_addr, dmem_wdata,
      input  imem_we, imem_re, imem_addr, imem_wdata,
      input  tx_start, tx_byte
   );
endinterface

// File: rtl/uart_mem_load_ctrl.sv
// Host load/readback sequencer: stalls the CPU, borrows the data-memory port,
// then writes a word or reads one and streams it MSB byte first to the UART.
module uart_mem_load_ctrl #(
   parameter int ADDR_W       = 9,
   parameter int DATA_W       = 32,
   parameter int DRAIN_CYCLES = 2,
   parameter int RD_LATENCY   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   uart_mem_load_ctrl_if.master  bus
);
   typedef enum logic [2:0] {
      IDLE, DRAIN, WRITE, RD_ISSUE, RD_WAIT, TX_LOAD, TX_GAP, TX_WAIT
   } state_t;

   localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
   localparam logic [3:0] RD_LAST    = 4'(RD_LATENCY - 1);

   state_t            state_reg, state_next;
   logic [DATA_W-1:0] data_reg, data_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic              mem_type_reg, mem_type_next;
   logic              rw_reg, rw_next;
   logic [DATA_W-1:0] shift_reg, shift_next;
   logic [1:0]        byte_cnt_reg, byte_cnt_next;
   logic [3:0]        wait_cnt_reg, wait_cnt_next;

   logic              busy;
   logic              ctl_we;
   logic              ctl_re;
   logic              tx_start;
   logic [DATA_W-1:0] rd_word;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         data_reg     <= '0;
         addr_reg     <= '0;
         mem_type_reg <= 1'b0;
         rw_reg       <= 1'b0;
         shift_reg    <= '0;
         byte_cnt_reg <= '0;
         wait_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         data_reg     <= data_next;
         addr_reg     <= addr_next;
         mem_type_reg <= mem_type_next;
         rw_reg       <= rw_next;
         shift_reg    <= shift_next;
         byte_cnt_reg <= byte_cnt_next;
         wait_cnt_reg <= wait_cnt_next;
      end
   end

   assign rd_word = mem_type_reg ? bus.dmem_rdata : bus.imem_rdata;

   always_comb begin
      state_next    = state_reg;
      data_next     = data_reg;
      addr_next     = addr_reg;
      mem_type_next = mem_type_reg;
      rw_next       = rw_reg;
      shift_next    = shift_reg;
      byte_cnt_next = byte_cnt_reg;
      wait_cnt_next = wait_cnt_reg;
      ctl_we        = 1'b0;
      ctl_re        = 1'b0;
      tx_start      = 1'b0;

      case (state_reg)
         IDLE: begin
            if (bus.rx_done) begin
               data_next     = bus.rx_data;
               addr_next     = bus.rx_addr;
               mem_type_next = bus.rx_mem_type;
               rw_next       = bus.rx_rw;
               wait_cnt_next = '0;
               state_next    = DRAIN;
            end
         end
         DRAIN: begin
            if (wait_cnt_reg == DRAIN_LAST) begin
               wait_cnt_next = '0;
               state_next    = rw_reg ? WRITE : RD_ISSUE;
            end else begin
               wait_cnt_next = wait_cnt_reg + 4'd1;
            end
         end
         WRITE: begin
            ctl_we     = 1'b1;
            state_next = IDLE;
         end
         RD_ISSUE: begin
            ctl_re        = 1'b1;
            wait_cnt_next = '0;
            state_next    = RD_WAIT;
         end
         RD_WAIT: begin
            // rdata is valid on the RD_LATENCY-th cycle after the read strobe
            if (wait_cnt_reg == RD_LAST) begin
               shift_next    = rd_word;
               byte_cnt_next = '0;
               wait_cnt_next = '0;
               state_next    = TX_LOAD;
            end else begin
               wait_cnt_next = wait_cnt_reg + 4'd1;
            end
         end
         TX_LOAD: begin
            if (!bus.tx_busy) begin
               tx_start   = 1'b1;
               state_next = TX_GAP;
            end
         end
         TX_GAP: begin
            // transmitter raises busy one cycle after tx_start
            state_next = TX_WAIT;
         end
         TX_WAIT: begin
            if (!bus.tx_busy) begin
               shift_next    = {shift_reg[DATA_W-9:0], 8'h00};
               byte_cnt_next = byte_cnt_reg + 2'd1;
               state_next    = (byte_cnt_reg == 2'd3) ? IDLE : TX_LOAD;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy           = (state_reg != IDLE);
   assign bus.busy       = busy;
   assign bus.cpu_stall  = busy;
   assign bus.rx_dropped = bus.rx_done & busy;

   // CPU owns the data port only while idle; its requests are dropped otherwise
   assign bus.dmem_we    = busy ? (ctl_we & mem_type_reg) : bus.cpu_dmem_we;
   assign bus.dmem_re    = busy ? (ctl_re & mem_type_reg) : bus.cpu_dmem_re;
   assign bus.dmem_addr  = busy ? addr_reg : bus.cpu_dmem_addr;
   assign bus.dmem_wdata = busy ? data_reg : bus.cpu_dmem_wdata;

   assign bus.imem_we    = ctl_we & ~mem_type_reg;
   assign bus.imem_re    = ctl_re & ~mem_type_reg;
   assign bus.imem_addr  = ((ctl_we | ctl_re) & ~mem_type_reg) ? addr_reg : '0;
   assign bus.imem_wdata = (ctl_we & ~mem_type_reg) ? data_reg : '0;

   assign bus.tx_start   = tx_start;
   assign bus.tx_byte    = tx_start ? shift_reg[DATA_W-1 -: 8] : 8'h00;
endmodule
